// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud timing derivation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Clock cycles per bit period (integer division).
  function automatic int unsigned cyc_count(input int unsigned sys_clk,
                                            input int unsigned baud);
    return sys_clk / baud;
  endfunction

  function automatic int unsigned half_count(input int unsigned cyc);
    return cyc / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit mid-point qualification, then one sample per bit period.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYSTEM_CLOCK = 32000000,
  parameter int unsigned BAUD_RATE    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CYC_COUNT = cyc_count(SYSTEM_CLOCK, BAUD_RATE);
  localparam int unsigned HALF      = half_count(CYC_COUNT);
  localparam int unsigned CW        = $clog2(CYC_COUNT) + 1;
  localparam int unsigned LAST_BIT  = DATA_BITS - 1;

  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CYC_COUNT - 1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);

  logic              din_s;
  uart_state_e       state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              ferr_q;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (din),
    .q_o (din_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!din_s) begin
            state_q <= ST_START;
          end
        end

        // A start bit still low at its mid-point is genuine; otherwise it was a glitch.
        ST_START: begin
          if (cnt_q == CNT_HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= din_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {din_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'(LAST_BIT)) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_STOP: begin
          if (cnt_q == CNT_BIT_LAST) begin
            cnt_q <= '0;
            if (din_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // Hold off after a bad stop bit so a long break reports only once.
        ST_WAIT_IDLE: begin
          cnt_q <= '0;
          if (din_s) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a 9600 baud @ 32 MHz instance and a fast 16-cycle-per-bit instance.
`timescale 1ps/1ps
module tb_uart_rx;

  localparam int     S_CYC  = 3333;
  localparam int     F_CYC  = 16;
  localparam int     F_HALF = 8;
  localparam longint CLK_PS = 10000;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       s_rst, s_din, s_valid, s_ferr, s_busy;
  logic       f_rst, f_din, f_valid, f_ferr, f_busy;
  logic [7:0] s_dout, f_dout;

  exp_t   q_s[$];
  exp_t   q_f[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint f_evt_cyc = 0;

  always #5000 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.SYSTEM_CLOCK(32000000), .BAUD_RATE(9600)) u_slow (
    .clk(clk), .rst(s_rst), .din(s_din), .data_out(s_dout),
    .valid(s_valid), .frame_err(s_ferr), .busy(s_busy)
  );

  uart_rx #(.SYSTEM_CLOCK(153600), .BAUD_RATE(9600)) u_fast (
    .clk(clk), .rst(f_rst), .din(f_din), .data_out(f_dout),
    .valid(f_valid), .frame_err(f_ferr), .busy(f_busy)
  );

  // Monitors: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (f_valid || f_ferr) begin
      exp_t e;
      checks++;
      f_evt_cyc = cyc;
      if (f_valid && f_ferr) begin
        errors++;
        $display("FAIL f_exclusive valid=%0b frame_err=%0b required only one high", f_valid, f_ferr);
      end else if (q_f.size() == 0) begin
        errors++;
        $display("FAIL f_unexpected valid=%0b frame_err=%0b data=%02h required no pulse", f_valid, f_ferr, f_dout);
      end else begin
        e = q_f.pop_front();
        if (f_ferr != e.is_err || f_dout != e.data) begin
          errors++;
          $display("FAIL f_event frame_err=%0b data=%02h required frame_err=%0b data=%02h",
                   f_ferr, f_dout, e.is_err, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (s_valid || s_ferr) begin
      exp_t e;
      checks++;
      if (s_valid && s_ferr) begin
        errors++;
        $display("FAIL s_exclusive valid=%0b frame_err=%0b required only one high", s_valid, s_ferr);
      end else if (q_s.size() == 0) begin
        errors++;
        $display("FAIL s_unexpected valid=%0b frame_err=%0b data=%02h required no pulse", s_valid, s_ferr, s_dout);
      end else begin
        e = q_s.pop_front();
        if (s_ferr != e.is_err || s_dout != e.data) begin
          errors++;
          $display("FAIL s_event frame_err=%0b data=%02h required frame_err=%0b data=%02h",
                   s_ferr, s_dout, e.is_err, e.data);
        end
      end
    end
  end

  initial begin
    #(longint'(60000) * CLK_PS);
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input bit fast, input logic v);
    if (fast) f_din = v;
    else      s_din = v;
  endtask

  task automatic push(input bit fast, input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    if (fast) q_f.push_back(e);
    else      q_s.push_back(e);
  endtask

  // Line is left at the stop level so frames chain back-to-back and a 0 stop becomes a break.
  task automatic send_frame(input bit fast, input logic [7:0] b, input logic stop_bit, input longint bit_ps);
    drive(fast, 1'b0);
    #(bit_ps);
    for (int i = 0; i < 8; i++) begin
      drive(fast, b[i]);
      #(bit_ps);
    end
    drive(fast, stop_bit);
    #(bit_ps);
  endtask

  task automatic wait_drain(input bit fast, input int max_cyc);
    int n = 0;
    while (((fast ? q_f.size() : q_s.size()) != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if ((fast ? q_f.size() : q_s.size()) != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0 after %0d cycles",
               fast ? "f" : "s", fast ? q_f.size() : q_s.size(), max_cyc);
    end
  endtask

  task automatic run_fast();
    longint c0;
    longint fbit = F_CYC * CLK_PS;
    f_rst = 1'b1;
    f_din = 1'b1;
    repeat (4) @(negedge clk);
    check("f_rst_dout", f_dout, 0);
    check("f_rst_busy", f_busy, 0);
    check("f_rst_valid", f_valid, 0);
    check("f_rst_ferr", f_ferr, 0);
    f_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("f_idle_after_rst_busy", f_busy, 0);

    // 0xA5 with latency measurement from the line falling edge
    c0 = cyc;
    push(1'b1, 1'b0, 8'hA5);
    send_frame(1'b1, 8'hA5, 1'b1, fbit);
    wait_drain(1'b1, 40);
    checks++;
    if (f_evt_cyc - c0 < F_HALF + 9 * F_CYC + 2 || f_evt_cyc - c0 > F_HALF + 9 * F_CYC + 4) begin
      errors++;
      $display("FAIL f_latency actual=%0d required=%0d+-1", f_evt_cyc - c0, F_HALF + 9 * F_CYC + 3);
    end
    check("f_dout_a5", f_dout, 8'hA5);

    // back-to-back frames, no idle gap
    push(1'b1, 1'b0, 8'h00);
    push(1'b1, 1'b0, 8'hFF);
    send_frame(1'b1, 8'h00, 1'b1, fbit);
    send_frame(1'b1, 8'hFF, 1'b1, fbit);
    wait_drain(1'b1, 40);
    check("f_dout_ff", f_dout, 8'hFF);

    // short low glitch on idle line
    repeat (32) @(negedge clk);
    f_din = 1'b0;
    repeat (F_HALF / 2) @(negedge clk);
    f_din = 1'b1;
    check("f_glitch_busy_high", f_busy, 1);
    repeat (F_HALF + 3 - F_HALF / 2) @(negedge clk);
    check("f_glitch_busy_low", f_busy, 0);
    repeat (2 * F_CYC) @(negedge clk);

    // bad stop bit followed by a 20-bit break
    push(1'b1, 1'b1, 8'hFF);
    send_frame(1'b1, 8'h3C, 1'b0, fbit);
    #(20 * fbit);
    @(negedge clk);
    check("f_break_busy", f_busy, 1);
    check("f_break_pending", q_f.size(), 0);
    f_din = 1'b1;
    repeat (4) @(negedge clk);
    check("f_break_end_busy", f_busy, 0);
    check("f_break_dout_kept", f_dout, 8'hFF);
    repeat (2 * F_CYC) @(negedge clk);

    // reset during bit 4 of 0x5A; the sender then abandons the frame
    f_din = 1'b0;
    #(fbit);
    for (int i = 0; i < 4; i++) begin
      f_din = (i % 2 == 1);
      #(fbit);
    end
    f_din = 1'b1;
    repeat (F_HALF) @(negedge clk);
    f_rst = 1'b1;
    @(negedge clk);
    f_rst = 1'b0;
    check("f_midrst_dout", f_dout, 0);
    check("f_midrst_busy", f_busy, 0);
    repeat (2 * F_CYC) @(negedge clk);
    push(1'b1, 1'b0, 8'h81);
    send_frame(1'b1, 8'h81, 1'b1, fbit);
    wait_drain(1'b1, 40);
    check("f_dout_81", f_dout, 8'h81);

    // sender 3% slow, then 3% fast
    repeat (2 * F_CYC) @(negedge clk);
    push(1'b1, 1'b0, 8'h55);
    send_frame(1'b1, 8'h55, 1'b1, longint'(F_CYC) * 10300);
    repeat (2 * F_CYC) @(negedge clk);
    push(1'b1, 1'b0, 8'h55);
    send_frame(1'b1, 8'h55, 1'b1, longint'(F_CYC) * 9700);
    wait_drain(1'b1, 40);
    check("f_dout_55", f_dout, 8'h55);
  endtask

  task automatic run_slow();
    s_rst = 1'b1;
    s_din = 1'b1;
    repeat (4) @(negedge clk);
    check("s_rst_dout", s_dout, 0);
    check("s_rst_busy", s_busy, 0);
    s_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("s_idle_after_rst_busy", s_busy, 0);
    push(1'b0, 1'b0, 8'hA5);
    send_frame(1'b0, 8'hA5, 1'b1, S_CYC * CLK_PS);
    wait_drain(1'b0, 4000);
    check("s_dout_a5", s_dout, 8'hA5);
  endtask

  initial begin
    s_rst = 1'b1;
    f_rst = 1'b1;
    s_din = 1'b1;
    f_din = 1'b1;
    @(negedge clk);
    fork
      run_fast();
      run_slow();
    join
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
